// File: rtl/write_back_unit.sv
// write_back_unit
// Registered, handshaked write-back stage for an RV32/RV64 pipeline.
// Accepts one retiring instruction per cycle from execute. The register-file
// write data comes from the ALU result, from PC + PC_INC (link writes), or
// from a load response. A load response is lane-aligned and extended before
// it is written. Execute is back-pressured while a load is outstanding.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   ex_valid / ex_ready        instruction handshake from execute
//   ex_sel                     0 = MEM, 1 = ALU, 2 = PC, 3 = NONE
//   ex_rd                      destination register
//   ex_alu, ex_pc              ALU result, instruction PC
//   ex_ld_size                 0 = byte, 1 = half, 2 = word, 3 = dword
//   ex_ld_unsigned             zero-extend (1) or sign-extend (0) the load
//   ex_addr_lo                 low load-address bits, used for lane select
//   mem_rsp_valid/mem_rsp_data load response from data memory
//   rf_we/rf_waddr/rf_wdata    register-file write port (registered)
//   busy                       a load is outstanding
//   err_misalign               pulse: misaligned load, its write suppressed
//   err_spurious               pulse: response arrived with no load pending
module write_back_unit #(
  parameter int XLEN       = 32,  // 32 or 64
  parameter int REG_ADDR_W = 5,
  parameter int PC_INC     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [1:0]            ex_sel,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]       ex_alu,
  input  logic [XLEN-1:0]       ex_pc,
  input  logic [1:0]            ex_ld_size,
  input  logic                  ex_ld_unsigned,
  input  logic [2:0]            ex_addr_lo,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  busy,
  output logic                  err_misalign,
  output logic                  err_spurious
);

  localparam logic [1:0] SEL_MEM = 2'd0;
  localparam logic [1:0] SEL_ALU = 2'd1;
  localparam logic [1:0] SEL_PC  = 2'd2;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                  state_q;
  logic                    rf_we_q;
  logic [REG_ADDR_W-1:0]   rf_waddr_q;
  logic [XLEN-1:0]         rf_wdata_q;
  logic                    err_misalign_q;
  logic                    err_spurious_q;

  // Fields of the outstanding load, captured at acceptance.
  logic [REG_ADDR_W-1:0]   ld_rd_q;
  logic [1:0]              ld_size_q;
  logic                    ld_uns_q;
  logic [2:0]              ld_lo_q;

  logic [XLEN-1:0]         ld_data_d;
  logic                    ld_mis_d;

  // Misaligned when the address is not a multiple of the access size.
  // A doubleword does not exist on a 32-bit datapath, so it always faults.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] lo);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = lo[0];
      2'd2:    mis = (lo[1:0] != 2'b00);
      default: mis = (XLEN == 32) ? 1'b1 : (lo != 3'b000);
    endcase
    return mis;
  endfunction

  // Shift the selected lane down to bit 0, then sign- or zero-fill above it.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                  input logic [1:0]      size,
                                                  input logic            uns,
                                                  input logic [2:0]      lo);
    logic [2:0]      off;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            sgn;
    case (size)
      2'd0:    off = lo;
      2'd1:    off = {lo[2:1], 1'b0};
      2'd2:    off = {lo[2], 2'b00};
      default: off = 3'b000;
    endcase
    // A 32-bit word holds only four byte lanes; address bit 2 selects nothing.
    if (XLEN == 32) off[2] = 1'b0;
    sh = raw >> {off, 3'b000};
    case (size)
      2'd0:    begin mask = XLEN'(8'hFF);         sgn = sh[7];      end
      2'd1:    begin mask = XLEN'(16'hFFFF);      sgn = sh[15];     end
      2'd2:    begin mask = XLEN'(32'hFFFF_FFFF); sgn = sh[31];     end
      default: begin mask = '1;                   sgn = sh[XLEN-1]; end
    endcase
    if (sgn && !uns) return sh | ~mask;
    return sh & mask;
  endfunction

  always_comb begin
    ld_data_d = load_extend(mem_rsp_data, ld_size_q, ld_uns_q, ld_lo_q);
    ld_mis_d  = is_misaligned(ld_size_q, ld_lo_q);
  end

  // FSM and registered write-port / error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      err_misalign_q <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      // Pulsed outputs default low; write address/data hold between writes.
      rf_we_q        <= 1'b0;
      err_misalign_q <= 1'b0;
      err_spurious_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A response with nothing outstanding is dropped and flagged;
          // it does not disturb an instruction accepted in the same cycle.
          if (mem_rsp_valid) err_spurious_q <= 1'b1;
          if (ex_valid) begin
            case (ex_sel)
              SEL_ALU: begin
                if (ex_rd != '0) begin
                  rf_we_q    <= 1'b1;
                  rf_waddr_q <= ex_rd;
                  rf_wdata_q <= ex_alu;
                end
              end
              SEL_PC: begin
                if (ex_rd != '0) begin
                  rf_we_q    <= 1'b1;
                  rf_waddr_q <= ex_rd;
                  rf_wdata_q <= ex_pc + XLEN'(PC_INC);
                end
              end
              SEL_MEM: begin
                ld_rd_q   <= ex_rd;
                ld_size_q <= ex_ld_size;
                ld_uns_q  <= ex_ld_unsigned;
                ld_lo_q   <= ex_addr_lo;
                state_q   <= WAIT_MEM;
              end
              default: ;  // NONE: retire without a write
            endcase
          end
        end
        WAIT_MEM: begin
          if (mem_rsp_valid) begin
            state_q <= IDLE;
            if (ld_mis_d) begin
              err_misalign_q <= 1'b1;
            end else if (ld_rd_q != '0) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= ld_rd_q;
              rf_wdata_q <= ld_data_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign busy         = (state_q == WAIT_MEM);
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign err_misalign = err_misalign_q;
  assign err_spurious = err_spurious_q;

endmodule
